// File: rtl/fifo_prog.sv
// +----------------------------------------------------------------------------
// | fifo_prog : single-clock FIFO, any DEPTH >= 2, programmable almost flags,
// |             sticky overflow/underflow, synchronous flush, FWFT or registered read.
// | Revision  : 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module fifo_prog #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 1
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_flush,
  input  logic                         i_clr_err,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_write,
  input  logic                         i_read,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_almost_full,
  output logic                         o_almost_empty,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int c_lw = $clog2(DEPTH + 1);
  localparam int c_pw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_pw-1:0]  r_rptr;
  logic [c_pw-1:0]  r_wptr;
  logic [c_lw-1:0]  r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_rd_ok;
  logic w_wr_ok;

  function automatic logic [c_pw-1:0] f_inc(input logic [c_pw-1:0] p);
    return (p == c_pw'(DEPTH - 1)) ? '0 : p + c_pw'(1);
  endfunction

  // Acceptance is judged before flush so that a flushed request never raises an error.
  assign w_full   = (r_level == c_lw'(DEPTH));
  assign w_rd_acc = i_read && (r_level != '0);
  assign w_wr_acc = i_write && (!w_full || w_rd_acc);
  assign w_rd_ok  = w_rd_acc && !i_flush;
  assign w_wr_ok  = w_wr_acc && !i_flush;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= f_inc(r_wptr);
      if (w_rd_ok) r_rptr <= f_inc(r_rptr);
      if (w_wr_ok && !w_rd_ok)      r_level <= r_level + c_lw'(1);
      else if (w_rd_ok && !w_wr_ok) r_level <= r_level - c_lw'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (!i_flush && i_write && !w_wr_acc) r_overflow <= 1'b1;
      else if (i_clr_err)                   r_overflow <= 1'b0;
      if (!i_flush && i_read && !w_rd_acc)  r_underflow <= 1'b1;
      else if (i_clr_err)                   r_underflow <= 1'b0;
    end
  end

  assign o_level        = r_level;
  assign o_full         = w_full;
  assign o_empty        = (r_level == '0);
  assign o_almost_full  = (r_level >= c_lw'(AF_LEVEL));
  assign o_almost_empty = (r_level <= c_lw'(AE_LEVEL));
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_data  = r_mem[r_rptr];
      assign o_valid = (r_level != '0);
    end else begin : g_regread
      logic [WIDTH-1:0] r_data;
      logic             r_valid;
      always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_ok;
          if (w_rd_ok) r_data <= r_mem[r_rptr];
        end
      end
      assign o_data  = r_data;
      assign o_valid = r_valid;
    end

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_prog: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("fifo_prog: AE_LEVEL out of range 0..DEPTH-1");
    end
  endgenerate

endmodule

`default_nettype wire
